// File: rtl/fp_mult_pkg.sv
// Shared types and bit indices for the fp multiplier result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_mult_pkg;

  // Multiplier status bit positions
  localparam int ST_INEXACT = 0;
  localparam int ST_TINY    = 1;
  localparam int ST_HUGE    = 2;
  localparam int ST_NAN     = 3;
  localparam int ST_INF     = 4;
  localparam int ST_ZERO    = 5;
  localparam int N_FLAGS    = 6;

  // Sticky error bit positions
  localparam int ERR_OVF = 0;  // push dropped while full
  localparam int ERR_UNF = 1;  // result arrived with nothing in flight

  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  status;
  } fp_result_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through read of mem[rd_ptr].
// Latency: push visible at the head one cycle later; no empty bypass.
// Backpressure: push while full without a pop is dropped and flagged on drop.
module fp_sync_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             push_acc,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_acc;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_acc  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_acc = push & (~full | pop_acc);
  assign drop     = push & ~push_acc;
  assign rdata    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of 2); count is explicit occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_mult_result_buffer.sv
// Buffers fixed-latency multiplier results and issues credits so the pipe never overflows.
// Latency: in_valid to out_valid is 1 cycle; head is fall-through from registers.
// Backpressure: out_ready stalls the head; upstream is throttled by issue_ok. FP_STICKY_FLAGS_EN adds sticky flags.
module fp_mult_result_buffer
  import fp_mult_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_fire,
  output logic        issue_ok,
  input  logic        in_valid,
  input  logic [31:0] in_z,
  input  logic [7:0]  in_status,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [7:0]  out_status,
  output logic [AW:0] count,
  output logic [1:0]  err
`ifdef FP_STICKY_FLAGS_EN
  ,
  input  logic        flags_clr,
  output logic [N_FLAGS-1:0] flags
`endif
);

  fp_result_t    wr_res;
  fp_result_t    rd_res;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_acc;
  logic          drop;
  logic          pop;
  logic [AW:0]   inflight;
  logic [AW+1:0] occupancy;

  assign wr_res = '{z: in_z, status: in_status};

  fp_sync_fifo #(
    .WIDTH($bits(fp_result_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .pop      (pop),
    .wdata    (wr_res),
    .rdata    (rd_res),
    .count    (count),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .push_acc (push_acc),
    .drop     (drop)
  );

  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign out_z      = out_valid ? rd_res.z      : '0;
  assign out_status = out_valid ? rd_res.status : '0;

  // Credit: stored plus still in the multiplier pipe must leave a free slot.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign issue_ok  = (occupancy < (AW+2)'(DEPTH));

  // Track operations in the multiplier pipe; saturate rather than wrap on misuse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue_fire && !in_valid) begin
      if (inflight != '1) inflight <= inflight + (AW+1)'(1);
    end else if (!issue_fire && in_valid && (inflight != '0)) begin
      inflight <= inflight - (AW+1)'(1);
    end
  end

  // Sticky protocol errors, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      if (drop)                           err[ERR_OVF] <= 1'b1;
      if (in_valid && (inflight == '0))   err[ERR_UNF] <= 1'b1;
    end
  end

`ifdef FP_STICKY_FLAGS_EN
  // Sticky exception flags: clear first, then OR in the newly stored status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (push_acc) begin
      flags <= (flags_clr ? '0 : flags) | in_status[N_FLAGS-1:0];
    end else if (flags_clr) begin
      flags <= '0;
    end
  end
`endif

endmodule
